// File: rtl/act_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one activation unit among N requesters.
// Accepts a Q16.16 operand, evaluates it once, returns the result with its id.
module act_share_arbiter #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic [W-1:0]   act_x,
  input  logic [W-1:0]   act_y,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [W-1:0]   resp_data,
  output logic [IDW-1:0] resp_id,
  output logic           busy,
  output logic [15:0]    op_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [IDW-1:0] id_q, id_d;
  logic [15:0]    op_count_q, op_count_d;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] gnt_nxt;
  int             idx;

  // First valid requester at or after rr_ptr, searching upward modulo N.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    gnt_nxt = IDW'((int'(gnt_idx) + 1) % N);
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    x_d        = x_q;
    y_d        = y_q;
    id_d       = id_q;
    op_count_d = op_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          x_d      = req_data[int'(gnt_idx)*W +: W];
          id_d     = gnt_idx;
          rr_ptr_d = gnt_nxt;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        y_d     = act_y;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      id_q       <= id_d;
      op_count_q <= op_count_d;
    end
  end

  assign act_x      = x_q;
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = y_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != S_IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_act_share_arbiter.sv
// Directed bench for act_share_arbiter.
// Activation model: act_y = act_x + 1.0 (Q16.16).
module tb_act_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   act_x;
  logic [W-1:0]   act_y;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [W-1:0]   resp_data;
  logic [IDW-1:0] resp_id;
  logic           busy;
  logic [15:0]    op_count;

  logic [W-1:0] val [N];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic bad_gnt = 1'b0;
  logic seen_rv = 1'b0;

  assign req_data = {val[3], val[2], val[1], val[0]};
  assign act_y = act_x + 32'h0001_0000;

  act_share_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .act_x(act_x), .act_y(act_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en && (req_ready[0] || req_ready[2])) bad_gnt = 1'b1;
    if (mon_en && resp_valid) seen_rv = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_resp(output int at);
    logic ok;
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (resp_valid) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    chk("resp_timeout", 64'(ok), 64'd1);
  endtask

  int t, tp;
  logic [IDW-1:0] exp_id [5];
  logic [IDW-1:0] fair_id [4];

  initial begin
    for (int i = 0; i < N; i++) val[i] = '0;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    fair_id = '{2'd1, 2'd3, 2'd1, 2'd3};

    // Reset values
    req_valid = 4'b1111;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_act_x", 64'(act_x), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    do_reset();

    // Single request
    @(negedge clk);
    val[2] = 32'h0000_8000;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    chk("single_eval_busy", 64'(busy), 64'd1);
    chk("single_eval_rdy", 64'(req_ready), 64'd0);
    chk("single_act_x", 64'(act_x), 64'h8000);
    step();
    chk("single_rv", 64'(resp_valid), 64'd1);
    chk("single_data", 64'(resp_data), 64'h0001_8000);
    chk("single_id", 64'(resp_id), 64'd2);
    step();
    chk("single_cnt", 64'(op_count), 64'd1);
    chk("single_idle", 64'(busy), 64'd0);

    // Contention
    do_reset();
    val[0] = 32'h10; val[1] = 32'h20;
    val[2] = 32'h30; val[3] = 32'h40;
    req_valid = 4'b1111;
    tp = 0;
    for (int k = 0; k < 5; k++) begin
      wait_resp(t);
      chk($sformatf("cont_id%0d", k), 64'(resp_id), 64'(exp_id[k]));
      chk($sformatf("cont_data%0d", k), 64'(resp_data),
          64'(val[exp_id[k]] + 32'h0001_0000));
      if (k > 0) chk($sformatf("cont_gap%0d", k), 64'(t - tp), 64'd3);
      tp = t;
    end
    req_valid = '0;
    step();
    step();

    // Fairness skip
    do_reset();
    bad_gnt = 1'b0;
    mon_en = 1'b1;
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_resp(t);
      chk($sformatf("fair_id%0d", k), 64'(resp_id), 64'(fair_id[k]));
    end
    mon_en = 1'b0;
    req_valid = '0;
    chk("fair_no_0_2", 64'(bad_gnt), 64'd0);

    // Backpressure
    do_reset();
    resp_ready = 1'b0;
    val[1] = 32'h1234_5678;
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1000;
    step();
    chk("bp_rv0", 64'(resp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp_rv%0d", k + 1), 64'(resp_valid), 64'd1);
      chk($sformatf("bp_data%0d", k + 1), 64'(resp_data), 64'h1235_5678);
      chk($sformatf("bp_id%0d", k + 1), 64'(resp_id), 64'd1);
      chk($sformatf("bp_rdy%0d", k + 1), 64'(req_ready), 64'd0);
      chk($sformatf("bp_cnt%0d", k + 1), 64'(op_count), 64'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("bp_cnt_after", 64'(op_count), 64'd1);
    chk("bp_rv_after", 64'(resp_valid), 64'd0);
    req_valid = '0;
    step();
    step();
    step();

    // Reset mid-op
    do_reset();
    val[2] = 32'h0005_0000;
    req_valid = 4'b0100;
    step();
    chk("rmo_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rmo_busy0", 64'(busy), 64'd0);
    chk("rmo_act_x0", 64'(act_x), 64'd0);
    chk("rmo_rv0", 64'(resp_valid), 64'd0);
    chk("rmo_ready0", 64'(req_ready), 64'd0);
    chk("rmo_data0", 64'(resp_data), 64'd0);
    seen_rv = 1'b0;
    mon_en = 1'b1;
    req_valid = '0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step();
    mon_en = 1'b0;
    chk("rmo_no_resp", 64'(seen_rv), 64'd0);
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("rmo_ptr0", 64'(req_ready), 64'b0001);
    req_valid = '0;

    // Counter wrap (preload near the top instead of 65534 real ops)
    do_reset();
    @(negedge clk);
    force dut.op_count_q = 16'hfffe;
    #1;
    release dut.op_count_q;
    val[0] = 32'h0;
    req_valid = 4'b0001;
    wait_resp(t);
    step();
    chk("wrap_ffff", 64'(op_count), 64'hffff);
    wait_resp(t);
    step();
    chk("wrap_0000", 64'(op_count), 64'h0000);
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
